// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//   Shared definitions for the shift/rotate unit and its iterative inverse.
//   Contents:
//     OP_SHL/OP_SHR/OP_ROL/OP_ROR : 2-bit operation encodings (control word [1:0])
//     AMT_HI/AMT_LO, OP_HI/OP_LO  : bit positions of the fields in the 8-bit control word
//     state_e                     : sequencer states of the unshifter
//     eff_count()                 : number of one-bit inverse steps for a control word
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam logic [1:0] OP_SHL = 2'b00;
    localparam logic [1:0] OP_SHR = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam int unsigned AMT_HI = 7;
    localparam int unsigned AMT_LO = 4;
    localparam int unsigned OP_HI  = 1;
    localparam int unsigned OP_LO  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Logical shifts saturate at 8 (everything is gone by then); rotates
    // wrap every 8 positions, so only the low three amount bits matter.
    function automatic logic [3:0] eff_count(input logic [3:0] amt,
                                             input logic [1:0] op);
        logic [3:0] n;
        if (op == OP_SHL || op == OP_SHR) begin
            n = amt[3] ? 4'd8 : amt;
        end else begin
            n = {1'b0, amt[2:0]};
        end
        return n;
    endfunction

endpackage

// File: rtl/unshift_step.sv
// -----------------------------------------------------------------------------
// unshift_step
//   Purely combinational single-position inverse of the shift/rotate unit.
//   Undoes one bit of the forward operation on the working value and tracks
//   which bit positions still hold genuine operand data.
//   Ports:
//     work_i     [WIDTH-1:0] : partially reconstructed operand
//     mask_i     [WIDTH-1:0] : 1 = corresponding work bit is exact
//     op_i       [1:0]       : forward operation being inverted
//     work_nxt_o [WIDTH-1:0] : operand after one more inverse step
//     mask_nxt_o [WIDTH-1:0] : validity mask after one more inverse step
// -----------------------------------------------------------------------------
module unshift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] work_i,
    input  logic [WIDTH-1:0] mask_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] work_nxt_o,
    output logic [WIDTH-1:0] mask_nxt_o
);

    always_comb begin
        work_nxt_o = work_i;
        mask_nxt_o = mask_i;
        case (op_i)
            // A left shift pushed the top bit out: move back right and mark
            // the vacated MSB as unknown.
            OP_SHL: begin
                work_nxt_o = {1'b0, work_i[WIDTH-1:1]};
                mask_nxt_o = {1'b0, mask_i[WIDTH-1:1]};
            end
            OP_SHR: begin
                work_nxt_o = {work_i[WIDTH-2:0], 1'b0};
                mask_nxt_o = {mask_i[WIDTH-2:0], 1'b0};
            end
            // Rotates lose nothing, so the mask passes through untouched.
            OP_ROL: begin
                work_nxt_o = {work_i[0], work_i[WIDTH-1:1]};
            end
            OP_ROR: begin
                work_nxt_o = {work_i[WIDTH-2:0], work_i[WIDTH-1]};
            end
            default: begin
                work_nxt_o = work_i;
                mask_nxt_o = mask_i;
            end
        endcase
    end

endmodule

// File: rtl/unshifter_seq.sv
// -----------------------------------------------------------------------------
// unshifter_seq
//   Iterative inverse of the 8-bit shift/rotate unit. Given the shifted value
//   and the control word that produced it, rebuilds the original operand one
//   bit position per clock and reports which bits are recoverable.
//   Ports:
//     clk        : rising-edge clock
//     rst_n      : asynchronous active-low reset
//     start      : request, accepted only in IDLE while el is low
//     el         : active-low enable; high during SHIFT aborts the operation
//     y_in       : shifted value to invert
//     b_in       : control word, [7:4] amount, [1:0] op, [3:2] unused
//     a_out      : reconstructed operand, held until the next accepted start
//     known_mask : 1 = bit of a_out is exact, 0 = bit was discarded (reads 0)
//     busy       : high while in SHIFT or DONE
//     done       : one-cycle pulse when a_out/known_mask are valid
//     sflag      : set with done when every bit was recovered
// -----------------------------------------------------------------------------
module unshifter_seq
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             el,
    input  logic [WIDTH-1:0] y_in,
    input  logic [7:0]       b_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] known_mask,
    output logic             busy,
    output logic             done,
    output logic             sflag
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] km_q, km_d;
    logic             sflag_q, sflag_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_work;
    logic [WIDTH-1:0] step_mask;

    logic             accept;
    logic             step_en;
    logic             finish;

    // Control word bits [3:2] carry no meaning for the inverse.
    logic             unused_b_bits;
    assign unused_b_bits = ^b_in[3:2];

    unshift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .work_i     (work_q),
        .mask_i     (mask_q),
        .op_i       (op_q),
        .work_nxt_o (step_work),
        .mask_nxt_o (step_mask)
    );

    assign accept  = (state_q == IDLE)  && start && !el;
    assign step_en = (state_q == SHIFT) && !el && (cnt_q != '0);
    assign finish  = (state_q == SHIFT) && !el && (cnt_q == '0);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !el) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Abort takes priority over finishing on the same edge.
                if (el) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy = (state_q != IDLE);
    end

    // ------------------------------------------------------------- datapath
    always_comb begin
        work_d  = work_q;
        mask_d  = mask_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        km_d    = km_q;
        sflag_d = sflag_q;
        done_d  = 1'b0;

        if (accept) begin
            work_d  = y_in;
            mask_d  = '1;
            op_d    = b_in[OP_HI:OP_LO];
            cnt_d   = CNT_W'(eff_count(b_in[AMT_HI:AMT_LO], b_in[OP_HI:OP_LO]));
            sflag_d = 1'b0;
        end

        if (step_en) begin
            work_d = step_work;
            mask_d = step_mask;
            cnt_d  = cnt_q - CNT_W'(1);
        end

        if (finish) begin
            a_d     = work_q;
            km_d    = mask_q;
            sflag_d = (mask_q == '1);
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q  <= '0;
            mask_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            km_q    <= '0;
            sflag_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            work_q  <= work_d;
            mask_q  <= mask_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            km_q    <= km_d;
            sflag_q <= sflag_d;
            done_q  <= done_d;
        end
    end

    assign a_out      = a_q;
    assign known_mask = km_q;
    assign done       = done_q;
    assign sflag      = sflag_q;

endmodule
